wb_burst_arbiter: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 23 ++
 rtl/wb_rr_grant.sv | 20 ++
 rtl/wb_burst_arbiter.sv | 157 +++++++++++++++
 tb/tb_wb_burst_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and Wishbone cycle/burst encodings for the two-master burst arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        ABORT = 2'd3
    } arb_state_t;

    // Cycle type identifier values
    localparam logic [2:0] CLASSIC = 3'b000;
    localparam logic [2:0] CONST   = 3'b001;
    localparam logic [2:0] INCR    = 3'b010;
    localparam logic [2:0] EOB     = 3'b111;

    // Burst type extension values
    localparam logic [1:0] LINEAR  = 2'b00;
    localparam logic [1:0] WRAP4   = 2'b01;
    localparam logic [1:0] WRAP8   = 2'b10;
    localparam logic [1:0] WRAP16  = 2'b11;

endpackage

// File: rtl/wb_rr_grant.sv
// Two-requester round-robin picker: a lone requester wins outright, a tie goes
// to whichever master did not own the bus last.
module wb_rr_grant (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    // One-hot pick from the request pair and the previous owner
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/wb_burst_arbiter.sv
// Two-master, one-slave Wishbone B4 arbiter. The grant is held for a whole bus
// cycle so CTI/BTE bursts stay atomic; a stall watchdog aborts hung transfers.
module wb_burst_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    // master 0
    input  logic [ADDR_WIDTH-1:0]   m0_adr,
    input  logic [DATA_WIDTH-1:0]   m0_dat_w,
    output logic [DATA_WIDTH-1:0]   m0_dat_r,
    input  logic                    m0_cyc,
    input  logic                    m0_stb,
    input  logic                    m0_we,
    input  logic [DATA_WIDTH/8-1:0] m0_sel,
    input  logic [2:0]              m0_cti,
    input  logic [1:0]              m0_bte,
    output logic                    m0_ack,
    output logic                    m0_err,
    // master 1
    input  logic [ADDR_WIDTH-1:0]   m1_adr,
    input  logic [DATA_WIDTH-1:0]   m1_dat_w,
    output logic [DATA_WIDTH-1:0]   m1_dat_r,
    input  logic                    m1_cyc,
    input  logic                    m1_stb,
    input  logic                    m1_we,
    input  logic [DATA_WIDTH/8-1:0] m1_sel,
    input  logic [2:0]              m1_cti,
    input  logic [1:0]              m1_bte,
    output logic                    m1_ack,
    output logic                    m1_err,
    // slave
    output logic [ADDR_WIDTH-1:0]   s_adr,
    output logic [DATA_WIDTH-1:0]   s_dat_w,
    input  logic [DATA_WIDTH-1:0]   s_dat_r,
    output logic [DATA_WIDTH/8-1:0] s_sel,
    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [2:0]              s_cti,
    output logic [1:0]              s_bte,
    input  logic                    s_ack,
    input  logic                    s_err,
    output logic [1:0]              grant
);

    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT - 1);

    arb_state_t  state, state_next;
    logic        last, last_next;
    logic        owner, owner_next;
    logic [15:0] wdog, wdog_next;
    logic        abort_first, abort_first_next;
    logic [1:0]  pick;
    logic        in_own;
    logic        owner_cyc;
    logic        owner_stb;
    logic        stall;

    wb_rr_grant u_rr_grant (
        .req  ({m1_cyc, m0_cyc}),
        .last (last),
        .pick (pick)
    );

    // State, round-robin history, current owner, watchdog and the one-shot abort flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last        <= 1'b1;
            owner       <= 1'b0;
            wdog        <= 16'd0;
            abort_first <= 1'b0;
        end else begin
            state       <= state_next;
            last        <= last_next;
            owner       <= owner_next;
            wdog        <= wdog_next;
            abort_first <= abort_first_next;
        end
    end

    // Slave side follows the owner register; outside OWN states cyc/stb are held low
    always_comb begin
        in_own    = (state == OWN0) || (state == OWN1);
        owner_cyc = owner ? m1_cyc : m0_cyc;
        owner_stb = owner ? m1_stb : m0_stb;
        s_adr     = owner ? m1_adr   : m0_adr;
        s_dat_w   = owner ? m1_dat_w : m0_dat_w;
        s_sel     = owner ? m1_sel   : m0_sel;
        s_we      = owner ? m1_we    : m0_we;
        s_cti     = owner ? m1_cti   : m0_cti;
        s_bte     = owner ? m1_bte   : m0_bte;
        s_cyc     = in_own & owner_cyc;
        s_stb     = in_own & owner_stb;
        stall     = s_stb & ~s_ack & ~s_err;
    end

    // Next-state logic: arbitrate in IDLE, hold for the whole cycle, watchdog in OWN
    always_comb begin
        state_next       = state;
        last_next        = last;
        owner_next       = owner;
        wdog_next        = 16'd0;
        abort_first_next = 1'b0;
        case (state)
            IDLE: begin
                if (pick[0]) begin
                    state_next = OWN0;
                    owner_next = 1'b0;
                end else if (pick[1]) begin
                    state_next = OWN1;
                    owner_next = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (!owner_cyc) begin
                    state_next = IDLE;
                    last_next  = owner;
                end else if (stall) begin
                    if (wdog == WDOG_LIMIT) begin
                        state_next       = ABORT;
                        abort_first_next = 1'b1;
                    end else begin
                        wdog_next = wdog + 16'd1;
                    end
                end
            end
            ABORT: begin
                if (!owner_cyc) begin
                    state_next = IDLE;
                    last_next  = owner;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Responses reach only the owner; the abort error is a single registered pulse
    always_comb begin
        m0_dat_r = s_dat_r;
        m1_dat_r = s_dat_r;
        m0_ack   = (state == OWN0) & s_ack;
        m1_ack   = (state == OWN1) & s_ack;
        m0_err   = ((state == OWN0) & s_err) | ((state == ABORT) & abort_first & ~owner);
        m1_err   = ((state == OWN1) & s_err) | ((state == ABORT) & abort_first & owner);
        grant    = 2'b00;
        if (state == OWN0)       grant = 2'b01;
        else if (state == OWN1)  grant = 2'b10;
        else if (state == ABORT) grant = owner ? 2'b10 : 2'b01;
    end

endmodule

// File: tb/tb_wb_burst_arbiter.sv
// Directed bench for wb_burst_arbiter with a small word-addressed SRAM slave model.
`timescale 1ns/1ps
module tb_wb_burst_arbiter;
    import wb_arb_pkg::*;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] m0_adr, m1_adr, s_adr;
    logic [DW-1:0] m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r, s_dat_w, s_dat_r;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [SW-1:0] m0_sel, m1_sel, s_sel;
    logic [2:0]    m0_cti, m1_cti, s_cti;
    logic [1:0]    m0_bte, m1_bte, s_bte;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we, s_ack, s_err;
    logic [1:0]    grant;

    logic [DW-1:0] mem [0:255];
    logic          ack_en;

    int compareCount = 0;
    int mismatchCount = 0;
    int waited;
    int acks;
    int adrv;

    wb_burst_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
        .m0_cti(m0_cti), .m0_bte(m0_bte), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
        .m1_cti(m1_cti), .m1_bte(m1_bte), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_sel(s_sel),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_cti(s_cti), .s_bte(s_bte),
        .s_ack(s_ack), .s_err(s_err), .grant(grant)
    );

    always #5 clk = ~clk;

    // Zero-wait SRAM slave; ack can be withheld to provoke the watchdog
    assign s_ack   = s_cyc & s_stb & ack_en;
    assign s_err   = 1'b0;
    assign s_dat_r = mem[s_adr[7:0]];

    // Byte-lane writes on acknowledged write beats
    always @(posedge clk) begin
        if (s_cyc && s_stb && s_ack && s_we)
            for (int b = 0; b < SW; b++)
                if (s_sel[b]) mem[s_adr[7:0]][8*b +: 8] <= s_dat_w[8*b +: 8];
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                                 input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                                 input logic [2:0] cti, input logic [1:0] bte);
        if (m == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr;
            m0_dat_w = dat; m0_sel = 4'hF; m0_cti = cti; m0_bte = bte;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr;
            m1_dat_w = dat; m1_sel = 4'hF; m1_cti = cti; m1_bte = bte;
        end
    endtask

    task automatic idleMaster(input int m);
        applyStimulus(m, 1'b0, 1'b0, 1'b0, '0, '0, CLASSIC, LINEAR);
    endtask

    task automatic nextDrive();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for an ack to master m; returns at the negedge where it is seen
    task automatic waitAck(input int m, input string tag, output int cycles);
        logic got;
        got = 1'b0;
        cycles = 0;
        while (!got && cycles < 20) begin
            @(negedge clk);
            got = (m == 0) ? m0_ack : m1_ack;
            if (!got) cycles++;
        end
        checkOutput(tag, 64'(got), 64'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        reset = 1'b1;
        ack_en = 1'b1;
        idleMaster(0);
        idleMaster(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset grant", 64'(grant), 64'd0);
        checkOutput("reset s_cyc", 64'(s_cyc), 64'd0);
        checkOutput("reset s_stb", 64'(s_stb), 64'd0);
        checkOutput("reset acks/errs", 64'({m0_ack, m0_err, m1_ack, m1_err}), 64'd0);
        nextDrive();
        reset = 1'b0;

        // Single master: 4-beat INCR write burst at 0x10
        $display("[TB] single master INCR burst");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 30'h10, 32'hA0, INCR, LINEAR);
        @(negedge clk);
        checkOutput("t1 s_cyc before grant", 64'(s_cyc), 64'd0);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b1, 1'b1, 1'b1, 30'(16 + i), 32'(32'hA0 + i), (i == 3) ? EOB : INCR, LINEAR);
            waitAck(0, "t1 m0_ack", waited);
            if (m0_ack) acks++;
            checkOutput("t1 beat wait", 64'(waited), 64'd0);
            checkOutput("t1 grant", 64'(grant), 64'd1);
            checkOutput("t1 m1_ack", 64'(m1_ack), 64'd0);
            checkOutput("t1 s_adr", 64'(s_adr), 64'(16 + i));
            nextDrive();
        end
        checkOutput("t1 ack count", 64'(acks), 64'd4);
        idleMaster(0);
        @(negedge clk);
        checkOutput("t1 s_cyc follows drop", 64'(s_cyc), 64'd0);
        checkOutput("t1 grant held until edge", 64'(grant), 64'd1);
        @(negedge clk);
        checkOutput("t1 grant released", 64'(grant), 64'd0);
        nextDrive();

        // Contention right after reset, then round-robin ties in both directions
        $display("[TB] contention");
        reset = 1'b1;
        nextDrive();
        reset = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 30'h10, '0, CLASSIC, LINEAR);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 30'h11, '0, CLASSIC, LINEAR);
        @(negedge clk);
        checkOutput("t2 grant before arb", 64'(grant), 64'd0);
        @(negedge clk);
        checkOutput("t2 m0 wins first", 64'(grant), 64'd1);
        checkOutput("t2 m0_ack", 64'(m0_ack), 64'd1);
        checkOutput("t2 m1_ack blocked", 64'(m1_ack), 64'd0);
        checkOutput("t2 m0_dat_r", 64'(m0_dat_r), 64'hA0);
        nextDrive();
        idleMaster(0);
        @(negedge clk);
        checkOutput("t2 grant still m0", 64'(grant), 64'd1);
        checkOutput("t2 m1_ack while m0 drops", 64'(m1_ack), 64'd0);
        @(negedge clk);
        checkOutput("t2 idle gap", 64'(grant), 64'd0);
        @(negedge clk);
        checkOutput("t2 m1 granted", 64'(grant), 64'd2);
        checkOutput("t2 m1_ack", 64'(m1_ack), 64'd1);
        checkOutput("t2 m1_dat_r", 64'(m1_dat_r), 64'hA1);
        nextDrive();
        idleMaster(1);
        nextDrive();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 30'h10, '0, CLASSIC, LINEAR);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 30'h11, '0, CLASSIC, LINEAR);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t2 tie after m1 last", 64'(grant), 64'd1);
        nextDrive();
        idleMaster(0);
        idleMaster(1);
        nextDrive();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 30'h10, '0, CLASSIC, LINEAR);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 30'h11, '0, CLASSIC, LINEAR);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t2 tie after m0 last", 64'(grant), 64'd2);
        nextDrive();
        idleMaster(0);
        idleMaster(1);
        nextDrive();

        // Burst atomicity: m1 WRAP8 from 6 with m0 requesting mid-burst
        $display("[TB] WRAP8 burst atomicity");
        for (int i = 0; i < 8; i++) begin
            adrv = (6 + i) % 8;
            applyStimulus(1, 1'b1, 1'b1, 1'b1, 30'(adrv), 32'(32'hB0 + i), (i == 7) ? EOB : INCR, WRAP8);
            if (i == 3) applyStimulus(0, 1'b1, 1'b1, 1'b0, 30'h6, '0, CLASSIC, LINEAR);
            waitAck(1, "t3 m1_ack", waited);
            checkOutput("t3 grant held", 64'(grant), 64'd2);
            checkOutput("t3 s_adr", 64'(s_adr), 64'(adrv));
            checkOutput("t3 s_bte", 64'(s_bte), 64'(WRAP8));
            checkOutput("t3 m0_ack blocked", 64'(m0_ack), 64'd0);
            nextDrive();
        end
        idleMaster(1);
        @(negedge clk);
        checkOutput("t3 grant until drop edge", 64'(grant), 64'd2);
        @(negedge clk);
        checkOutput("t3 idle gap", 64'(grant), 64'd0);
        @(negedge clk);
        checkOutput("t3 m0 granted", 64'(grant), 64'd1);
        checkOutput("t3 m0 reads wrapped beat0", 64'(m0_dat_r), 64'hB0);
        nextDrive();
        idleMaster(0);
        nextDrive();

        // Watchdog: slave never acks, TIMEOUT=4
        $display("[TB] watchdog abort");
        ack_en = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 30'h20, '0, CLASSIC, LINEAR);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t4 s_cyc k=%0d", k), 64'(s_cyc), 64'((k >= 1 && k <= 4) ? 1 : 0));
            checkOutput($sformatf("t4 m0_err k=%0d", k), 64'(m0_err), 64'((k == 5) ? 1 : 0));
            checkOutput($sformatf("t4 grant k=%0d", k), 64'(grant), 64'((k == 0) ? 0 : 1));
        end
        checkOutput("t4 m1_err", 64'(m1_err), 64'd0);
        idleMaster(0);
        @(negedge clk);
        checkOutput("t4 grant after abort release", 64'(grant), 64'd0);
        nextDrive();

        // Ack arriving on the limit cycle beats the timeout
        $display("[TB] ack versus timeout");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 30'h21, '0, CLASSIC, LINEAR);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("t4b stalled", 64'({s_cyc, m0_ack}), 64'b10);
        @(posedge clk);
        #1;
        ack_en = 1'b1;
        @(negedge clk);
        checkOutput("t4b ack at limit", 64'(m0_ack), 64'd1);
        checkOutput("t4b no err at limit", 64'(m0_err), 64'd0);
        @(negedge clk);
        checkOutput("t4b no abort err", 64'(m0_err), 64'd0);
        checkOutput("t4b s_cyc kept", 64'(s_cyc), 64'd1);
        nextDrive();
        idleMaster(0);
        nextDrive();

        // Reset during beat 2 of an m0 INCR burst
        $display("[TB] reset mid-burst");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b1, 1'b1, 1'b1, 30'(48 + i), 32'(32'hC0 + i), INCR, LINEAR);
            waitAck(0, "t5 m0_ack", waited);
            if (i < 2) nextDrive();
        end
        #1;
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 30'h11, '0, CLASSIC, LINEAR);
        reset = 1'b1;
        #1;
        checkOutput("t5 async grant", 64'(grant), 64'd0);
        checkOutput("t5 async s_cyc", 64'(s_cyc), 64'd0);
        checkOutput("t5 async m0_ack", 64'(m0_ack), 64'd0);
        nextDrive();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5 idle after reset", 64'(grant), 64'd0);
        @(negedge clk);
        checkOutput("t5 m0 regranted first", 64'(grant), 64'd1);
        nextDrive();
        idleMaster(0);
        idleMaster(1);
        nextDrive();

        // Write by m0, readback by m1
        $display("[TB] write then readback");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 30'h3, 32'hDEADBEEF, CLASSIC, LINEAR);
        waitAck(0, "t6 write ack", waited);
        checkOutput("t6 s_we", 64'(s_we), 64'd1);
        checkOutput("t6 s_sel", 64'(s_sel), 64'hF);
        checkOutput("t6 s_dat_w", 64'(s_dat_w), 64'hDEADBEEF);
        nextDrive();
        idleMaster(0);
        nextDrive();
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 30'h3, '0, CLASSIC, LINEAR);
        waitAck(1, "t6 read ack", waited);
        checkOutput("t6 m1_dat_r", 64'(m1_dat_r), 64'hDEADBEEF);
        checkOutput("t6 grant", 64'(grant), 64'd2);
        checkOutput("t6 m0_ack", 64'(m0_ack), 64'd0);
        nextDrive();
        idleMaster(1);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
